// File: rtl/seq_obf_core.sv
// seq_obf_core: key-sequence-locked sequential benchmark core.
//
// A small functional core (SW-bit register with an input-mixed LFSR
// next-state function and an inverted-MSB output) sits behind a state
// obfuscation FSM. The FSM must see KL key words on DIN, back to back,
// before DOUT carries the true function. Until then DOUT shows the
// un-inverted MSB, i.e. the corrupted output. The core itself always runs.
//
// Optional feature macro: SEQ_OBF_TRAP_EN
//   defined   - any key mismatch sends the FSM to an absorbing TRAP state
//   undefined - a mismatch restarts the key sequence at word 0
//
// Obfuscation FSM (mode + word index):
//   state      | meaning
//   MODE_OBF   | waiting for key word idx (idx = 0 .. KL-1)
//   MODE_FUNC  | unlocked, DOUT correct, absorbing until RST
//   MODE_TRAP  | wrong key seen, locked until RST (SEQ_OBF_TRAP_EN only)

module seq_obf_core #(
  parameter int              DW      = 4,
  parameter int              SW      = 3,
  parameter int              KL      = 4,
  parameter logic [KL*DW-1:0] KEY_SEQ = 16'hAC53,
  parameter logic [SW-1:0]   TAPS    = 3'b110
) (
  input  logic          CK,
  input  logic          RST,
  input  logic [DW-1:0] DIN,
  output logic          DOUT,
  output logic          UNLOCKED
);

  // Index register must be at least one bit wide, even for KL == 1.
  localparam int IW = (KL > 1) ? $clog2(KL) : 1;

`ifdef SEQ_OBF_TRAP_EN
  typedef enum logic [1:0] {
    MODE_OBF  = 2'd0,
    MODE_FUNC = 2'd1,
    MODE_TRAP = 2'd2
  } mode_t;
`else
  typedef enum logic [1:0] {
    MODE_OBF  = 2'd0,
    MODE_FUNC = 2'd1
  } mode_t;
`endif

  mode_t         mode;
  mode_t         mode_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          unlock_edge;

  logic [DW-1:0] key_word;
  logic          last_word;

  logic [SW-1:0] s;
  logic [SW-1:0] dinx;
  logic          fb;
  logic [SW-1:0] s_adv;

  // Current expected key word and whether it is the final one.
  always_comb begin
    key_word  = KEY_SEQ[int'(idx)*DW +: DW];
    last_word = (idx == IW'(KL - 1));
  end

  // DIN folded onto the state width: zero-extend when narrower, truncate
  // when wider. Only the low SW bits ever reach the core.
  generate
    if (DW >= SW) begin : g_din_trunc
      assign dinx = DIN[SW-1:0];
    end else begin : g_din_ext
      assign dinx = {{(SW - DW){1'b0}}, DIN};
    end
  endgenerate

  // LFSR step with input mixing; this runs in every FSM state.
  always_comb begin
    fb    = ^(s & TAPS);
    s_adv = {s[SW-2:0], fb} ^ dinx;
  end

  // Next-state logic of the obfuscation FSM. A mismatch never re-checks
  // the offending word against word 0; it only restarts (or traps).
  always_comb begin
    mode_next   = mode;
    idx_next    = idx;
    unlock_edge = 1'b0;
    case (mode)
      MODE_OBF: begin
        if (DIN == key_word) begin
          if (last_word) begin
            mode_next   = MODE_FUNC;
            idx_next    = '0;
            unlock_edge = 1'b1;
          end else begin
            idx_next = idx + IW'(1);
          end
        end else begin
`ifdef SEQ_OBF_TRAP_EN
          mode_next = MODE_TRAP;
`endif
          idx_next  = '0;
        end
      end
      default: begin
        mode_next = mode;
        idx_next  = idx;
      end
    endcase
  end

  // State registers. Reset wins over everything; the unlock edge clears
  // the core so functional operation starts from a known state, and that
  // edge's DIN is deliberately not absorbed.
  always_ff @(posedge CK) begin
    if (RST) begin
      mode <= MODE_OBF;
      idx  <= '0;
      s    <= '0;
    end else begin
      mode <= mode_next;
      idx  <= idx_next;
      s    <= unlock_edge ? '0 : s_adv;
    end
  end

  // Outputs come from registers only; locked states show the raw MSB.
  always_comb begin
    UNLOCKED = (mode == MODE_FUNC);
    DOUT     = UNLOCKED ? ~s[SW-1] : s[SW-1];
  end

endmodule

// File: tb/tb_seq_obf_core.sv
// tb_seq_obf_core: directed test of seq_obf_core with default parameters.
// Key words in order: 3, 5, C, A. Expectations adapt to SEQ_OBF_TRAP_EN.

module tb_seq_obf_core;

`ifdef SEQ_OBF_TRAP_EN
  localparam logic TRAP_BUILD = 1'b1;
`else
  localparam logic TRAP_BUILD = 1'b0;
`endif

  logic       ck = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       dout;
  logic       unlocked;

  int total = 0;
  int bad   = 0;

  seq_obf_core dut (
    .CK       (ck),
    .RST      (rst),
    .DIN      (din),
    .DOUT     (dout),
    .UNLOCKED (unlocked)
  );

  always #5 ck = ~ck;

  // single comparison point: counts and reports a mismatch
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic [3:0] d);
    @(negedge ck);
    rst = r;
    din = d;
    @(posedge ck);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] s_exp,
                         input logic dout_exp, input logic unl_exp);
    chk({tag, ".s"},    {5'd0, dut.s}, {5'd0, s_exp});
    chk({tag, ".dout"}, {7'd0, dout},  {7'd0, dout_exp});
    chk({tag, ".unl"},  {7'd0, unlocked}, {7'd0, unl_exp});
  endtask

  task automatic do_reset();
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
  endtask

  initial begin
    rst = 1'b1;
    din = 4'hF;

    // reset with DIN = F for two edges
    do_reset();
    chk_all("reset", 3'b000, 1'b0, 1'b0);

    // unlock; core keeps advancing while locked, output shows raw MSB
    step(1'b0, 4'h3); chk_all("key0", 3'b011, 1'b0, 1'b0);
    step(1'b0, 4'h5); chk_all("key1", 3'b010, 1'b0, 1'b0);
    step(1'b0, 4'hC); chk_all("key2", 3'b001, 1'b0, 1'b0);
    step(1'b0, 4'hA); chk_all("key3_unlock", 3'b000, 1'b1, 1'b1);

    // data in FUNC, including truncation of DIN[3] and a key word as data
    step(1'b0, 4'h1); chk_all("data1", 3'b001, 1'b1, 1'b1);
    step(1'b0, 4'h0); chk_all("data0a", 3'b010, 1'b1, 1'b1);
    step(1'b0, 4'h0); chk_all("data0b", 3'b101, 1'b0, 1'b1);
    step(1'b0, 4'h8); chk_all("data8", 3'b011, 1'b1, 1'b1);
    step(1'b0, 4'hF); chk_all("dataF", 3'b000, 1'b1, 1'b1);
    step(1'b0, 4'h4); chk_all("data4", 3'b100, 1'b0, 1'b1);
    step(1'b0, 4'h3); chk_all("data3_func", 3'b010, 1'b1, 1'b1);

    // reset while in FUNC
    step(1'b1, 4'h5); chk_all("rst_func", 3'b000, 1'b0, 1'b0);

    // partial key 3,5,7 then full key
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b0, 4'h7); chk_all("partial357", 3'b010, 1'b0, 1'b0);
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b0, 4'hC); chk({"retry_c", ".unl"}, {7'd0, unlocked}, 8'd0);
    step(1'b0, 4'hA); chk({"retry_a", ".unl"}, {7'd0, unlocked}, {7'd0, ~TRAP_BUILD});

    // partial key 3,7 then full key
    do_reset();
    step(1'b0, 4'h3);
    step(1'b0, 4'h7); chk({"partial37", ".unl"}, {7'd0, unlocked}, 8'd0);
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b0, 4'hC);
    step(1'b0, 4'hA); chk({"after37", ".unl"}, {7'd0, unlocked}, {7'd0, ~TRAP_BUILD});
    step(1'b0, 4'h3); chk({"after37_hold", ".unl"}, {7'd0, unlocked}, {7'd0, ~TRAP_BUILD});

    // reset always recovers a clean unlock
    do_reset();
    chk_all("reset2", 3'b000, 1'b0, 1'b0);
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b0, 4'hC);
    step(1'b0, 4'hA); chk_all("unlock2", 3'b000, 1'b1, 1'b1);

    // a mismatching word is not re-matched against word 0
    do_reset();
    step(1'b0, 4'h3);
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b0, 4'hC);
    step(1'b0, 4'hA); chk({"no_rematch", ".unl"}, {7'd0, unlocked}, 8'd0);

    // corruption: locked DIN=1 gives S=001 and raw MSB on DOUT
    do_reset();
    step(1'b0, 4'h1); chk_all("corrupt", 3'b001, 1'b0, 1'b0);

    // reset on the third key edge, then resume
    do_reset();
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b1, 4'hC); chk_all("rst_mid", 3'b000, 1'b0, 1'b0);
    step(1'b0, 4'hA); chk({"rst_mid_a", ".unl"}, {7'd0, unlocked}, 8'd0);
    do_reset();
    step(1'b0, 4'h3);
    step(1'b0, 4'h5);
    step(1'b0, 4'hC);
    step(1'b0, 4'hA); chk_all("unlock3", 3'b000, 1'b1, 1'b1);
    step(1'b0, 4'h1); chk_all("func_corrupt", 3'b001, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
